// File: rtl/fp_mult_param.sv
// Iterative parametrised floating-point multiplier: radix-2 shift-add mantissa product, RNE rounding,
// flush-to-zero for subnormals. Define FP_MULT_FLAGS_EN to compute exception flags (else tied to zero).
module fp_mult_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [EXP_W+MAN_W:0] p,
    output logic [3:0]           flags
);
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int M      = MAN_W + 1;
    localparam int AW     = 2 * M;
    localparam int CW     = $clog2(M + 1);
    localparam int XW     = EXP_W + 2;
    localparam int BIAS_I = (1 << (EXP_W - 1)) - 1;
    localparam int EMAX_I = (1 << EXP_W) - 1;

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MUL, S_NORM, S_ROUND} state_t;

    state_t                state_q, state_d;
    logic [W-1:0]          opa_q, opa_d, opb_q, opb_d;
    logic [M-1:0]          mcand_q, mcand_d, mplier_q, mplier_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic signed [XW-1:0]  exp_q, exp_d;
    logic                  sign_q, sign_d;
    logic                  nan_q, nan_d, inf_q, inf_d, zero_q, zero_d;
    logic [W-1:0]          p_q, p_d;
    logic                  done_q, done_d;

    logic                  sa, sb;
    logic [EXP_W-1:0]      ea, eb;
    logic [MAN_W-1:0]      ma, mb;
    logic                  zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, spc_nan;
    logic signed [XW-1:0]  exp_sum;
    logic [M:0]            psum;

    assign {sa, ea, ma} = opa_q;
    assign {sb, eb, mb} = opb_q;
    // Subnormal inputs (exponent field zero) are flushed and decode as zero.
    assign zero_a  = (ea == '0);
    assign zero_b  = (eb == '0);
    assign inf_a   = (&ea) & (ma == '0);
    assign inf_b   = (&eb) & (mb == '0);
    assign nan_a   = (&ea) & (|ma);
    assign nan_b   = (&eb) & (|mb);
    assign spc_nan = nan_a | nan_b | (inf_a & zero_b) | (zero_a & inf_b);
    assign exp_sum = $signed({2'b00, ea} + {2'b00, eb} - XW'(BIAS_I));
    assign psum    = {1'b0, acc_q[AW-1:M]} + {1'b0, (mplier_q[0] ? mcand_q : {M{1'b0}})};

    // After NORM the leading one sits at acc[AW-1]; fraction, guard and sticky follow below it.
    logic [MAN_W-1:0]     frac;
    logic                 g, rs, inc, ovf_r, unf_r;
    logic [MAN_W:0]       frac_r;
    logic signed [XW-1:0] exp_r;

    assign frac   = acc_q[AW-2:M];
    assign g      = acc_q[M-1];
    assign rs     = |acc_q[M-2:0];
    assign inc    = g & (rs | frac[0]);
    assign frac_r = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
    assign exp_r  = exp_q + $signed({{(XW-1){1'b0}}, frac_r[MAN_W]});
    assign ovf_r  = (exp_r >= $signed(XW'(EMAX_I)));
    assign unf_r  = exp_r[XW-1] | (exp_r == '0);

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        nan_d    = nan_q;
        inf_d    = inf_q;
        zero_d   = zero_q;
        p_d      = p_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = b;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                mcand_d  = {1'b1, ma};
                mplier_d = {1'b1, mb};
                acc_d    = '0;
                cnt_d    = '0;
                exp_d    = exp_sum;
                sign_d   = sa ^ sb;
                nan_d    = spc_nan;
                inf_d    = ~spc_nan & (inf_a | inf_b);
                zero_d   = ~spc_nan & (zero_a | zero_b);
                state_d  = S_MUL;
            end
            S_MUL: begin
                acc_d    = {psum, acc_q[M-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(M - 1)) state_d = S_NORM;
            end
            S_NORM: begin
                // Left-justify instead of shifting right so no product bit is lost before rounding.
                if (acc_q[AW-1]) exp_d = exp_q + XW'(1);
                else             acc_d = acc_q << 1;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                if (nan_q)       p_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                else if (inf_q)  p_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                else if (zero_q) p_d = {sign_q, {(W-1){1'b0}}};
                else if (ovf_r)  p_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                else if (unf_r)  p_d = {sign_q, {(W-1){1'b0}}};
                else             p_d = {sign_q, exp_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            nan_q    <= 1'b0;
            inf_q    <= 1'b0;
            zero_q   <= 1'b0;
            p_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            nan_q    <= nan_d;
            inf_q    <= inf_d;
            zero_q   <= zero_d;
            p_q      <= p_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign p    = p_q;

`ifdef FP_MULT_FLAGS_EN
    logic       inv_q, inv_d;
    logic [3:0] flags_q, flags_d;
    logic       snan_a, snan_b;

    assign snan_a = nan_a & ~ma[MAN_W-1];
    assign snan_b = nan_b & ~mb[MAN_W-1];

    // Flag order {invalid, overflow, underflow, inexact}; quiet NaN inputs raise nothing.
    always_comb begin
        inv_d   = inv_q;
        flags_d = flags_q;
        if (state_q == S_UNPACK)
            inv_d = snan_a | snan_b | (inf_a & zero_b) | (zero_a & inf_b);
        if (state_q == S_ROUND) begin
            if (nan_q)                flags_d = {inv_q, 3'b000};
            else if (inf_q || zero_q) flags_d = 4'b0000;
            else if (ovf_r)           flags_d = 4'b0101;
            else if (unf_r)           flags_d = 4'b0011;
            else                      flags_d = {3'b000, g | rs};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv_q   <= 1'b0;
            flags_q <= 4'b0000;
        end else begin
            inv_q   <= inv_d;
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;
`else
    assign flags = 4'b0000;
`endif

endmodule

// File: tb/tb_fp_mult_param.sv
// Bench for fp_mult_param: f32 and half-precision instances, vector table, directed corner
// sequences and randomized operands against a value-level reference model.
module tb_fp_mult_param;
`ifdef FP_MULT_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif
    localparam int LAT32 = 23 + 4;  // edges after the accepting edge until done is visible
    localparam int LAT16 = 10 + 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a32, b32, p32;
    logic [15:0] a16, b16, p16;
    logic        start32, start16, busy32, busy16, done32, done16;
    logic [3:0]  fl32, fl16;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_mult_param #(.EXP_W(8), .MAN_W(23)) d32 (
        .clk(clk), .rst(rst), .a(a32), .b(b32), .start(start32),
        .busy(busy32), .done(done32), .p(p32), .flags(fl32));
    fp_mult_param #(.EXP_W(5), .MAN_W(10)) d16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .start(start16),
        .busy(busy16), .done(done16), .p(p16), .flags(fl16));

    typedef struct {
        logic [31:0] a, b, p;
        logic [3:0]  fl;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Value-level model: exact integer product, normalise, round-to-nearest-even, then range check.
    function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input int ew, input int mw);
        longint unsigned emax, bias, ex, ey, mx, my, mask, prod, q, rem, half, pv, sgn, qnan;
        longint e;
        int sh;
        bit nx, ny, ix, iy, zx, zy, snx, sny, inx;
        emax = (64'd1 << ew) - 1;
        bias = (64'd1 << (ew - 1)) - 1;
        mask = (64'd1 << mw) - 1;
        ex = (64'(x) >> mw) & emax;
        ey = (64'(y) >> mw) & emax;
        mx = 64'(x) & mask;
        my = 64'(y) & mask;
        sgn = ((64'(x) ^ 64'(y)) >> (ew + mw)) & 1;
        nx = (ex == emax) && (mx != 0);
        ny = (ey == emax) && (my != 0);
        ix = (ex == emax) && (mx == 0);
        iy = (ey == emax) && (my == 0);
        zx = (ex == 0);
        zy = (ey == 0);
        snx = nx && (((mx >> (mw - 1)) & 1) == 0);
        sny = ny && (((my >> (mw - 1)) & 1) == 0);
        qnan = (emax << mw) | (64'd1 << (mw - 1));
        if (nx || ny || (ix && zy) || (zx && iy))
            return {(snx || sny || (ix && zy) || (zx && iy)), 3'b000, 32'(qnan)};
        if (ix || iy) return {4'b0000, 32'((sgn << (ew + mw)) | (emax << mw))};
        if (zx || zy) return {4'b0000, 32'(sgn << (ew + mw))};
        prod = (mx | (64'd1 << mw)) * (my | (64'd1 << mw));
        e = longint'(ex) + longint'(ey) - longint'(bias);
        if ((prod >> (2 * mw + 1)) != 0) begin
            sh = mw + 1;
            e++;
        end else sh = mw;
        q    = prod >> sh;
        rem  = prod & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        inx  = (rem != 0);
        if (rem > half || (rem == half && q[0])) q++;
        if ((q >> (mw + 1)) != 0) begin
            q = q >> 1;
            e++;
        end
        if (e >= longint'(emax)) return {4'b0101, 32'((sgn << (ew + mw)) | (emax << mw))};
        if (e <= 0) return {4'b0011, 32'(sgn << (ew + mw))};
        pv = (sgn << (ew + mw)) | (64'(e) << mw) | (q & mask);
        return {3'b000, inx, 32'(pv)};
    endfunction

    // One start pulse, then count edges until done (bounded); samples 1 time unit after each edge.
    task automatic run_op(input bit sel, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] pr, output logic [3:0] fl, output int lat);
        @(negedge clk);
        if (sel) begin a16 = x[15:0]; b16 = y[15:0]; start16 = 1'b1; end
        else     begin a32 = x;       b32 = y;       start32 = 1'b1; end
        @(posedge clk);
        #1;
        start32 = 1'b0;
        start16 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!(sel ? done16 : done32) && lat < 200);
        pr = sel ? {16'h0, p16} : p32;
        fl = sel ? fl16 : fl32;
    endtask

    function automatic logic [31:0] rand_op(input int ew, input int mw);
        logic [31:0] x;
        int emax;
        emax = (1 << ew) - 1;
        x = $urandom;
        x = x & ((32'd1 << (1 + ew + mw)) - 1);
        case ($urandom_range(0, 7))
            0: x = (x & ~(32'(emax) << mw)) | (32'($urandom_range(0, 1) * emax) << mw);
            1: x = (x & ~(32'(emax) << mw)) | (32'($urandom_range(1, 3)) << mw);
            2: x = (x & ~(32'(emax) << mw)) | (32'(emax - $urandom_range(1, 3)) << mw);
            default: ;
        endcase
        return x;
    endfunction

    initial begin
        logic [31:0] pr, x, y;
        logic [3:0]  fl;
        logic [35:0] r;
        int lat, ndone, first;

        vt.push_back(vec_t'{32'h40200000, 32'h40E00000, 32'h418C0000, 4'b0000});
        vt.push_back(vec_t'{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000});
        vt.push_back(vec_t'{32'hBFC00000, 32'h40000000, 32'hC0400000, 4'b0000});
        vt.push_back(vec_t'{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101});
        vt.push_back(vec_t'{32'hFF7FFFFF, 32'h40000000, 32'hFF800000, 4'b0101});
        vt.push_back(vec_t'{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011});
        vt.push_back(vec_t'{32'h80800000, 32'h3F000000, 32'h80000000, 4'b0011});
        vt.push_back(vec_t'{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000});
        vt.push_back(vec_t'{32'hFFC00000, 32'h3F800000, 32'h7FC00000, 4'b0000});
        vt.push_back(vec_t'{32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000});
        vt.push_back(vec_t'{32'h00000000, 32'hC0400000, 32'h80000000, 4'b0000});
        vt.push_back(vec_t'{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000});
        vt.push_back(vec_t'{32'h80000000, 32'hFF800000, 32'h7FC00000, 4'b1000});
        vt.push_back(vec_t'{32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000});

        rst = 1'b1;
        start32 = 1'b0; start16 = 1'b0;
        a32 = '0; b32 = '0; a16 = '0; b16 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {busy32, done32, p32, fl32, busy16, done16, p16, fl16}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vt[i]) begin
            run_op(1'b0, vt[i].a, vt[i].b, pr, fl, lat);
            chk($sformatf("vec%0d_lat", i), lat, LAT32);
            chk($sformatf("vec%0d_p", i), pr, vt[i].p);
            chk($sformatf("vec%0d_flags", i), fl, FLAGS_ON ? vt[i].fl : 4'b0000);
            chk($sformatf("vec%0d_busy_on_done", i), busy32, 1'b0);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_done_pulse", i), {done32, p32}, {1'b0, vt[i].p});
        end

        // Start pulsed mid-operation must be ignored: one done, original result.
        @(negedge clk);
        a32 = 32'h3F800001; b32 = 32'h3F800001; start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        ndone = 0; first = 0; pr = '0;
        for (int i = 1; i <= 60; i++) begin
            if (i == 5) begin a32 = 32'h40000000; b32 = 32'h40000000; start32 = 1'b1; end
            if (i == 6) start32 = 1'b0;
            @(posedge clk);
            #1;
            if (done32) begin
                ndone++;
                if (first == 0) begin first = i; pr = p32; end
            end
        end
        chk("midop_done_count", ndone, 1);
        chk("midop_lat", first, LAT32);
        chk("midop_p", pr, 32'h3F800002);

        // Half precision, then a back-to-back start on the done cycle.
        run_op(1'b1, 32'h4000, 32'h4200, pr, fl, lat);
        chk("h16_lat", lat, LAT16);
        chk("h16_p", pr, 32'h4600);
        chk("h16_flags", fl, 4'b0000);
        a16 = 16'h4400; b16 = 16'h3C00; start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!done16 && lat < 200);
        chk("b2b_lat", lat, LAT16);
        chk("b2b_p", p16, 16'h4400);

        // Reset asserted during an operation clears outputs at once and aborts it.
        @(negedge clk);
        a32 = 32'h40200000; b32 = 32'h40E00000; start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_midop_outputs", {busy32, done32, p32, fl32, p16}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done32) ndone++;
        end
        chk("rst_no_done", ndone, 0);
        run_op(1'b0, 32'h40200000, 32'h40E00000, pr, fl, lat);
        chk("post_rst_lat", lat, LAT32);
        chk("post_rst_p", pr, 32'h418C0000);

        for (int i = 0; i < 150; i++) begin
            x = rand_op(8, 23);
            y = rand_op(8, 23);
            r = ref_mul(x, y, 8, 23);
            run_op(1'b0, x, y, pr, fl, lat);
            chk($sformatf("rnd32 %h*%h", x, y), {lat, pr, fl}, {LAT32, r[31:0], FLAGS_ON ? r[35:32] : 4'b0000});
        end
        for (int i = 0; i < 100; i++) begin
            x = rand_op(5, 10);
            y = rand_op(5, 10);
            r = ref_mul(x, y, 5, 10);
            run_op(1'b1, x, y, pr, fl, lat);
            chk($sformatf("rnd16 %h*%h", x[15:0], y[15:0]), {lat, pr, fl}, {LAT16, r[31:0], FLAGS_ON ? r[35:32] : 4'b0000});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
